dma_wb8: RTL and testbench

Single-channel byte-copy DMA engine for the 8-bit Wishbone SoC bus. It has a responder (slave) register port, which the CPU uses to program source, destination and length. It also has an initiator (master) port that performs the copy as alternating read/write bus cycles, honouring ACK and STALL. The top-level bus mux grants the master port priority whenever `O_m_cyc` is high, and the CPU is held off via its stall input. An optional completion interrupt is provided.

---
 rtl/dma_wb8_pkg.sv | 29 ++
 rtl/wb8_master_port.sv | 41 ++++
 rtl/dma_wb8.sv | 171 +++++++++++++++++
 tb/tb_dma_wb8.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_wb8_pkg.sv
// Shared definitions for the dma_wb8 byte-copy engine: register map,
// CTRL bit positions and engine state encoding.
package dma_wb8_pkg;

  localparam logic [3:0] REG_SRC0 = 4'h0;
  localparam logic [3:0] REG_DST0 = 4'h4;
  localparam logic [3:0] REG_LEN0 = 4'h8;
  localparam logic [3:0] REG_LEN1 = 4'h9;
  localparam logic [3:0] REG_CTRL = 4'hA;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_IRQEN   = 1;
  localparam int unsigned CTRL_CLRDONE = 2;
  localparam int unsigned CTRL_ABORT   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT
  } state_t;

  // Little-endian byte select out of a 32-bit register image.
  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] idx);
    return v[8*idx +: 8];
  endfunction

endpackage

// File: rtl/wb8_master_port.sv
// Wishbone initiator for one byte access. The sequencer says whether it is
// in the request phase (strobe out) or the wait phase (awaiting ack); this
// block drives the bus and reports acceptance, completion and read data.
module wb8_master_port #(
  parameter int unsigned ADDRBITS = 32
) (
  input  logic                req,
  input  logic                hold,
  input  logic                we,
  input  logic [ADDRBITS-1:0] adr,
  input  logic [7:0]          wdat,
  output logic                accepted,
  output logic                done,
  output logic [7:0]          rdata,
  output logic                m_cyc,
  output logic                m_stb,
  output logic                m_we,
  output logic [ADDRBITS-1:0] m_adr,
  output logic [7:0]          m_dat,
  input  logic [7:0]          m_rdat,
  input  logic                m_ack,
  input  logic                m_stall
);

  logic active;

  // Bus drive and handshake decode; address/data come straight from the
  // sequencer's registers, so they stay constant while stalled.
  always_comb begin
    active   = req | hold;
    m_cyc    = active;
    m_stb    = req;
    m_we     = active & we;
    m_adr    = active ? adr : '0;
    m_dat    = (active & we) ? wdat : '0;
    accepted = req & ~m_stall;
    done     = hold & m_ack;
    rdata    = m_rdat;
  end

endmodule

// File: rtl/dma_wb8.sv
// Single-channel byte-copy DMA for the 8-bit Wishbone bus: CPU register
// port plus a master port that alternates read and write cycles.
module dma_wb8
  import dma_wb8_pkg::*;
#(
  parameter int unsigned ADDRBITS = 32
) (
  input  logic                I_wb_clk,
  input  logic                I_reset_n,
  input  logic [3:0]          I_wb_adr,
  input  logic [7:0]          I_wb_dat,
  input  logic                I_wb_stb,
  input  logic                I_wb_we,
  output logic [7:0]          O_wb_dat,
  output logic                O_wb_ack,
  output logic [ADDRBITS-1:0] O_m_adr,
  output logic [7:0]          O_m_dat,
  input  logic [7:0]          I_m_dat,
  output logic                O_m_cyc,
  output logic                O_m_stb,
  output logic                O_m_we,
  input  logic                I_m_ack,
  input  logic                I_m_stall,
  output logic                O_interrupt
);

  state_t              state, state_next;
  logic [ADDRBITS-1:0] src, dst, src_wr, dst_wr;
  logic [15:0]         len;
  logic [7:0]          data_q, rdat, rmux;
  logic                done_q, irqen, abort_pend;
  logic                stb_q, ack_q, acc_we;
  logic [3:0]          acc_adr;
  logic [7:0]          acc_dat;
  logic                busy, reg_wr, wr_ctrl, start, clrdone, abort_req, finish;
  logic                mp_req, mp_hold, mp_we, mp_accepted, mp_done;
  logic [7:0]          mp_rdata;
  logic [31:0]         src32, dst32, src32_wr, dst32_wr;

  // A register access is captured on stb rising and committed in the ack
  // cycle, so a START acked at cycle N puts the strobe out at N+1.
  assign busy      = (state != ST_IDLE);
  assign reg_wr    = ack_q & acc_we;
  assign wr_ctrl   = reg_wr & (acc_adr == REG_CTRL);
  assign start     = wr_ctrl & acc_dat[CTRL_START] & ~busy;
  assign clrdone   = wr_ctrl & acc_dat[CTRL_CLRDONE];
  assign abort_req = abort_pend | (wr_ctrl & acc_dat[CTRL_ABORT] & busy);
  assign finish    = (state == ST_WR_WAIT) & mp_done & (len == 16'd1) & ~abort_req;

  assign mp_req  = (state == ST_RD_REQ) | (state == ST_WR_REQ);
  assign mp_hold = (state == ST_RD_WAIT) | (state == ST_WR_WAIT);
  assign mp_we   = (state == ST_WR_REQ) | (state == ST_WR_WAIT);

  assign O_wb_ack    = ack_q;
  assign O_wb_dat    = rdat;
  assign O_interrupt = done_q & irqen;

  wb8_master_port #(
    .ADDRBITS (ADDRBITS)
  ) u_port (
    .req      (mp_req),
    .hold     (mp_hold),
    .we       (mp_we),
    .adr      (mp_we ? dst : src),
    .wdat     (data_q),
    .accepted (mp_accepted),
    .done     (mp_done),
    .rdata    (mp_rdata),
    .m_cyc    (O_m_cyc),
    .m_stb    (O_m_stb),
    .m_we     (O_m_we),
    .m_adr    (O_m_adr),
    .m_dat    (O_m_dat),
    .m_rdat   (I_m_dat),
    .m_ack    (I_m_ack),
    .m_stall  (I_m_stall)
  );

  // Byte-merge images for SRC/DST writes and the register read mux.
  always_comb begin
    src32    = 32'(src);
    dst32    = 32'(dst);
    src32_wr = src32;
    dst32_wr = dst32;
    src32_wr[8*acc_adr[1:0] +: 8] = acc_dat;
    dst32_wr[8*acc_adr[1:0] +: 8] = acc_dat;
    src_wr   = ADDRBITS'(src32_wr);
    dst_wr   = ADDRBITS'(dst32_wr);
    rmux     = '0;
    if (I_wb_adr[3:2] == REG_SRC0[3:2])      rmux = byte_of(src32, I_wb_adr[1:0]);
    else if (I_wb_adr[3:2] == REG_DST0[3:2]) rmux = byte_of(dst32, I_wb_adr[1:0]);
    else if (I_wb_adr == REG_LEN0)           rmux = len[7:0];
    else if (I_wb_adr == REG_LEN1)           rmux = len[15:8];
    else if (I_wb_adr == REG_CTRL)           rmux = {5'b0, done_q, irqen, busy};
  end

  // Responder port: one ack per stb rising edge, read data latched with it.
  always_ff @(posedge I_wb_clk) begin
    if (!I_reset_n) begin
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
      acc_we  <= 1'b0;
      acc_adr <= '0;
      acc_dat <= '0;
      rdat    <= '0;
    end else begin
      stb_q <= I_wb_stb;
      ack_q <= I_wb_stb & ~stb_q;
      if (I_wb_stb && !stb_q) begin
        acc_we  <= I_wb_we;
        acc_adr <= I_wb_adr;
        acc_dat <= I_wb_dat;
        rdat    <= rmux;
      end
    end
  end

  // Working counters, status flags and the latched copy byte.
  always_ff @(posedge I_wb_clk) begin
    if (!I_reset_n) begin
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      irqen      <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (reg_wr && !busy) begin
        if (acc_adr[3:2] == REG_SRC0[3:2]) src <= src_wr;
        if (acc_adr[3:2] == REG_DST0[3:2]) dst <= dst_wr;
        if (acc_adr == REG_LEN0) len[7:0]  <= acc_dat;
        if (acc_adr == REG_LEN1) len[15:8] <= acc_dat;
      end
      if (wr_ctrl) irqen <= acc_dat[CTRL_IRQEN];
      if (state == ST_RD_WAIT && mp_done) begin
        data_q <= mp_rdata;
        src    <= src + ADDRBITS'(1);
      end
      if (state == ST_WR_WAIT && mp_done) begin
        dst <= dst + ADDRBITS'(1);
        if (len != '0) len <= len - 16'd1;
      end
      // Later assignments take priority: START overrides CLRDONE.
      if (clrdone) done_q <= 1'b0;
      if (start)   done_q <= (len == '0);
      if (finish)  done_q <= 1'b1;
      abort_pend <= abort_req & (state_next != ST_IDLE);
    end
  end

  // Engine state register.
  always_ff @(posedge I_wb_clk) begin
    if (!I_reset_n) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next-state: a pending abort is only acted on once the ack is in.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (start && len != '0) state_next = ST_RD_REQ;
      ST_RD_REQ:  if (mp_accepted) state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (mp_done) state_next = abort_req ? ST_IDLE : ST_WR_REQ;
      ST_WR_REQ:  if (mp_accepted) state_next = ST_WR_WAIT;
      ST_WR_WAIT: if (mp_done) state_next = (abort_req || len == 16'd1) ? ST_IDLE : ST_RD_REQ;
      default:    state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_wb8.sv
// Directed bench for dma_wb8: CPU register accesses, a memory responder on
// the master port with programmable stall/ack delay, and a scoreboard of
// expected bus transactions.
module tb_dma_wb8;

  logic        clk = 1'b0;
  logic        I_reset_n;
  logic [3:0]  I_wb_adr;
  logic [7:0]  I_wb_dat;
  logic        I_wb_stb;
  logic        I_wb_we;
  logic [7:0]  O_wb_dat;
  logic        O_wb_ack;
  logic [31:0] O_m_adr;
  logic [7:0]  O_m_dat;
  logic [7:0]  I_m_dat = 8'hEE;
  logic        O_m_cyc, O_m_stb, O_m_we;
  logic        I_m_ack = 1'b0;
  logic        I_m_stall = 1'b0;
  logic        O_interrupt;

  always #5 clk = ~clk;

  dma_wb8 #(.ADDRBITS(32)) dut (
    .I_wb_clk    (clk),
    .I_reset_n   (I_reset_n),
    .I_wb_adr    (I_wb_adr),
    .I_wb_dat    (I_wb_dat),
    .I_wb_stb    (I_wb_stb),
    .I_wb_we     (I_wb_we),
    .O_wb_dat    (O_wb_dat),
    .O_wb_ack    (O_wb_ack),
    .O_m_adr     (O_m_adr),
    .O_m_dat     (O_m_dat),
    .I_m_dat     (I_m_dat),
    .O_m_cyc     (O_m_cyc),
    .O_m_stb     (O_m_stb),
    .O_m_we      (O_m_we),
    .I_m_ack     (I_m_ack),
    .I_m_stall   (I_m_stall),
    .O_interrupt (O_interrupt)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  dat;
  } txn_t;

  txn_t        sb[$];
  int unsigned total = 0, bad = 0;
  int unsigned stall_cfg = 0, ack_delay = 0;
  int unsigned n_rd = 0, cyc_cycles = 0, cyc_rises = 0;
  logic        cyc_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return 8'(a[7:0] * 8'd7 + a[15:8] + 8'd3);
  endfunction

  // Memory responder: stalls each strobe stall_cfg cycles, then acks
  // ack_delay cycles after the cycle following acceptance.
  int unsigned stall_cnt = 0, ack_wait = 0;
  logic        outst = 1'b0;
  logic [40:0] snap = '0;
  logic [7:0]  rd_hold = '0;
  always @(negedge clk) begin
    txn_t e;
    I_m_ack = 1'b0;
    I_m_dat = 8'hEE;
    if (!I_reset_n) begin
      outst = 1'b0;
      stall_cnt = 0;
      I_m_stall = 1'b0;
    end else if (outst) begin
      I_m_stall = 1'b0;
      if (ack_wait == 0) begin
        I_m_ack = 1'b1;
        I_m_dat = rd_hold;
        outst = 1'b0;
      end else ack_wait--;
    end else if (O_m_stb) begin
      if (stall_cnt == 0) snap = {O_m_we, O_m_adr, O_m_dat};
      else check("stall_hold", {O_m_we, O_m_adr, O_m_dat}, snap);
      if (stall_cnt < stall_cfg) begin
        I_m_stall = 1'b1;
        stall_cnt++;
      end else begin
        I_m_stall = 1'b0;
        stall_cnt = 0;
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("bus_we", O_m_we, e.we);
          check("bus_adr", O_m_adr, e.adr);
          if (e.we) check("bus_dat", O_m_dat, e.dat);
        end
        if (!O_m_we) begin
          rd_hold = mem_byte(O_m_adr);
          n_rd++;
        end
        outst = 1'b1;
        ack_wait = ack_delay;
      end
    end else I_m_stall = 1'b0;
  end

  // Bus-cycle monitor.
  always @(negedge clk) begin
    if (O_m_cyc) cyc_cycles++;
    if (O_m_cyc && !cyc_prev) cyc_rises++;
    cyc_prev = O_m_cyc;
  end

  task automatic wb_access(input logic we, input logic [3:0] a, input logic [7:0] d,
                           output logic [7:0] q);
    int unsigned n = 0;
    @(negedge clk);
    I_wb_stb = 1'b1; I_wb_we = we; I_wb_adr = a; I_wb_dat = d;
    do begin
      @(negedge clk);
      n++;
    end while (!O_wb_ack && n < 8);
    q = O_wb_dat;
    check("wb_ack", O_wb_ack, 1);
    I_wb_stb = 1'b0; I_wb_we = 1'b0;
  endtask

  task automatic wb_wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_access(1'b1, a, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] q;
    wb_access(1'b0, a, 8'h00, q);
    check(tag, q, exp);
  endtask

  task automatic set_regs(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    logic [31:0] sv, dv;
    sv = s; dv = d;
    for (int i = 0; i < 4; i++) wb_wr(4'(i), sv[8*i +: 8]);
    for (int i = 0; i < 4; i++) wb_wr(4'(4 + i), dv[8*i +: 8]);
    wb_wr(4'h8, l[7:0]);
    wb_wr(4'h9, l[15:8]);
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      sb.push_back('{we: 1'b0, adr: s + i, dat: 8'h00});
      sb.push_back('{we: 1'b1, adr: d + i, dat: mem_byte(s + i)});
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (O_m_cyc && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", O_m_cyc, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int unsigned c0, r0, rd0, n;
    I_reset_n = 1'b0; I_wb_stb = 1'b0; I_wb_we = 1'b0; I_wb_adr = '0; I_wb_dat = '0;
    repeat (3) @(negedge clk);
    check("rst_cyc", O_m_cyc, 0);
    check("rst_stb", O_m_stb, 0);
    check("rst_ack", O_wb_ack, 0);
    check("rst_irq", O_interrupt, 0);
    I_reset_n = 1'b1;
    rd_chk("rst_ctrl", 4'hA, 8'h00);
    rd_chk("rst_len0", 4'h8, 8'h00);

    // Basic copy, zero stall, ack one cycle after strobe.
    set_regs(32'h100, 32'h200, 16'd4);
    push_copy(32'h100, 32'h200, 4);
    c0 = cyc_cycles; r0 = cyc_rises;
    wb_wr(4'hA, 8'h01);
    @(negedge clk);
    check("start_latency_stb", O_m_stb, 1);
    wait_idle();
    check("basic_cycles", cyc_cycles - c0, 16);
    check("basic_cyc_contig", cyc_rises - r0, 1);
    check("basic_sb_drained", sb.size(), 0);
    rd_chk("basic_ctrl", 4'hA, 8'h04);
    rd_chk("basic_len0", 4'h8, 8'h00);
    rd_chk("basic_len1", 4'h9, 8'h00);
    rd_chk("basic_src0", 4'h0, 8'h04);
    rd_chk("basic_src1", 4'h1, 8'h01);
    rd_chk("basic_dst0", 4'h4, 8'h04);
    rd_chk("basic_dst1", 4'h5, 8'h02);

    // Stall three cycles on each strobe, ack two cycles late.
    stall_cfg = 3; ack_delay = 2;
    set_regs(32'h300, 32'h380, 16'd3);
    push_copy(32'h300, 32'h380, 3);
    c0 = cyc_cycles;
    wb_wr(4'hA, 8'h01);
    @(negedge clk);
    wait_idle();
    check("stall_cycles", cyc_cycles - c0, 42);
    check("stall_sb_drained", sb.size(), 0);
    rd_chk("stall_ctrl", 4'hA, 8'h04);
    rd_chk("stall_src0", 4'h0, 8'h03);
    stall_cfg = 0; ack_delay = 0;

    // Zero length with IRQEN: DONE next cycle, no bus activity.
    wb_wr(4'h8, 8'h00);
    wb_wr(4'h9, 8'h00);
    c0 = cyc_cycles;
    wb_wr(4'hA, 8'h03);
    @(negedge clk);
    check("zero_irq", O_interrupt, 1);
    rd_chk("zero_ctrl", 4'hA, 8'h06);
    check("zero_no_cyc", cyc_cycles - c0, 0);
    wb_wr(4'hA, 8'h06);
    @(negedge clk);
    check("clrdone_irq", O_interrupt, 0);
    rd_chk("clrdone_ctrl", 4'hA, 8'h02);

    // Source address wrap.
    set_regs(32'hFFFF_FFFF, 32'h10, 16'd2);
    push_copy(32'hFFFF_FFFF, 32'h10, 2);
    wb_wr(4'hA, 8'h01);
    @(negedge clk);
    wait_idle();
    check("wrap_sb_drained", sb.size(), 0);
    rd_chk("wrap_src0", 4'h0, 8'h01);
    rd_chk("wrap_src3", 4'h3, 8'h00);
    rd_chk("wrap_dst0", 4'h4, 8'h12);

    // Abort while the third read is outstanding.
    ack_delay = 6;
    set_regs(32'h400, 32'h500, 16'd8);
    push_copy(32'h400, 32'h500, 2);
    sb.push_back('{we: 1'b0, adr: 32'h402, dat: 8'h00});
    c0 = cyc_cycles; rd0 = n_rd;
    wb_wr(4'hA, 8'h01);
    n = 0;
    while (n_rd != rd0 + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_third_read", n_rd - rd0, 3);
    wb_wr(4'hA, 8'h08);
    wait_idle();
    check("abort_cycles", cyc_cycles - c0, 40);
    check("abort_sb_drained", sb.size(), 0);
    rd_chk("abort_ctrl", 4'hA, 8'h00);
    rd_chk("abort_len0", 4'h8, 8'h06);
    rd_chk("abort_src0", 4'h0, 8'h03);
    rd_chk("abort_dst0", 4'h4, 8'h02);
    ack_delay = 0;

    // Interrupt with LEN=1, then reset mid-transfer.
    set_regs(32'h600, 32'h700, 16'd1);
    push_copy(32'h600, 32'h700, 1);
    wb_wr(4'hA, 8'h03);
    @(negedge clk);
    wait_idle();
    check("irq_set", O_interrupt, 1);
    rd_chk("irq_ctrl", 4'hA, 8'h06);
    wb_wr(4'hA, 8'h06);
    @(negedge clk);
    check("irq_cleared", O_interrupt, 0);

    ack_delay = 3;
    set_regs(32'h800, 32'h900, 16'd8);
    push_copy(32'h800, 32'h900, 8);
    wb_wr(4'hA, 8'h03);
    repeat (6) @(negedge clk);
    check("midxfer_cyc", O_m_cyc, 1);
    I_reset_n = 1'b0;
    @(negedge clk);
    check("reset_drop_cyc", O_m_cyc, 0);
    check("reset_drop_stb", O_m_stb, 0);
    @(negedge clk);
    I_reset_n = 1'b1;
    sb.delete();
    ack_delay = 0;
    for (int i = 0; i <= 10; i++) rd_chk("reset_reg", 4'(i), 8'h00);
    check("reset_irq", O_interrupt, 0);
    wb_wr(4'hB, 8'hFF);
    rd_chk("reserved_reg", 4'hB, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
